skipring_mc: RTL and testbench
==============================

// Module: skipring_mc
// PURPOSE
//  Multi-channel programmable clock-skip sequencer. A shared position counter walks a ring of
//  runtime-selectable length; each channel owns a LEN-bit skip mask and suppresses iCLK pulses
//  at masked positions. Masks are double-buffered and committed only at frame wrap, so patterns
//  change without partial frames. Sits between the board clock and the CPU/peripheral clock
//  inputs for per-domain rate thinning.
// PARAMETERS
//  LEN  16  maximum ring length (positions), >=2
//  CH    4  number of gated clock channels, >=1
//  LW   $clog2(LEN)           position/length field width (derived, do not override)
//  CW   max(1,$clog2(CH))     channel select width (derived, do not override)
// PORTS
//  iCLK    in   1       source clock; all state updates on negedge iCLK
//  nRST    in   1       asynchronous reset, active-low
//  E       in   1       enable: 1 = ring advances and masks act; 0 = pass-through, ring frozen
//  LENM1   in   LW      ring length minus 1; effective length = min(LENM1,LEN-1)+1
//  WE      in   1       shadow mask write strobe, sampled at negedge iCLK
//  WCH     in   CW      channel written by WE; WCH>=CH ignored
//  WMASK   in   LEN     mask data; bit p=1 skips the pulse at position p
//  oCLK    out  CH      gated clocks
//  oB0     out  1       frame marker: E & (pos==0)
//  oPOS    out  LW      current ring position
//  oPEND   out  1       a shadow write is awaiting commit
//  oSKIPS  out  CH*(LW+1)  per-channel skipped-pulse count of last completed frame (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (nRST=0, async): pos=0, active masks=0, shadows=0, oPEND=0, oSKIPS=0.
//    Hence oCLK[c]=iCLK, oB0=E, oPOS=0 during and after reset until masks are committed.
//  - Gating (combinational): oCLK[c] = iCLK & ~(E & amask[c][pos]). pos/amask change only
//    on negedge iCLK (iCLK low), so oCLK is glitch-free; no other term may feed the gate.
//  - Let L = min(LENM1,LEN-1) (LENM1 sampled every edge). wrap = (pos>=L).
//  - Advance (negedge, E=1): pos <= wrap ? 0 : pos+1. pos>L after LENM1 shrinks -> next pos 0.
//  - Mask bits at positions >L are never reached and have no effect.
//  - Write (negedge, WE=1, WCH<CH): shadow[WCH] <= WMASK; oPEND <= 1. Multiple writes per
//    frame: last write per channel wins. WE with WCH>=CH: no state change.
//  - Commit: on negedge with (E=1 & wrap) or E=0, and oPEND=1: amask[all] <= shadow[all],
//    oPEND <= 0. First position using new masks is pos 0 of the next frame (E=1) or the next
//    cycle (E=0).
//  - Simultaneous WE and commit: commit copies pre-write shadows; new write lands in shadow,
//    oPEND stays 1; it commits at the following wrap (or next negedge if E=0).
//  - E=0: pos, counters frozen; all channels pass iCLK; oB0=0.
//  - Reset mid-frame, either iCLK phase: outputs revert immediately to pass-through; no
//    runt pulse beyond what iCLK itself provides.
// CONFIGURATION
//  SKIPRING_SKIPSTAT_EN defined: per-channel counter of skipped positions accumulates during a
//   frame (E=1, amask[c][pos]=1); at wrap edge oSKIPS[c] <= final count incl. wrap position,
//   accumulator clears. Field c occupies oSKIPS[c*(LW+1) +: LW+1].
//  Not defined: no counters synthesised; oSKIPS tied to 0. Port list identical either way.
// TESTING
//  1 nRST=0 for 3 cycles, WE pulsed -> oCLK==iCLK all ch, oPOS=0, oPEND=0 after release.
//  2 LEN=16, LENM1=15, E=1, write ch0 WMASK=16'h0001 mid-frame -> oPEND=1 until wrap; then
//    oCLK[0] has 15 of 16 pulses, missing at oPOS=0; oB0 high once per 16 cycles; ch1-3 untouched.
//  3 LENM1=4, ch1 WMASK=16'hFFE5 -> 5-cycle frame, pulses skipped at pos 0 and 2 only (3 of 5).
//  4 WE (ch2, 16'h0002) on the wrap edge itself -> not applied next frame; oPEND=1;
//    applied the frame after.
//  5 E=0 with oPEND=1 -> commit on next negedge, oPOS frozen, oCLK==iCLK; E=1 resumes from frozen pos.
//  6 nRST asserted while iCLK high at pos 7 with mask active -> oCLK follows iCLK same cycle,
//    oPOS=0; with SKIPRING_SKIPSTAT_EN, ch0 mask 16'h00FF, LENM1=15 -> oSKIPS[0]=8 after wrap.

Source files
------------

// File: rtl/skipring_mc.sv
// Multi-channel clock-skip sequencer: shared ring position, per-channel double-buffered skip masks.
// Optional per-frame skip statistics enabled by defining SKIPRING_SKIPSTAT_EN.
module skipring_mc #(
    parameter int LEN = 16,
    parameter int CH  = 4,
    parameter int LW  = $clog2(LEN),
    parameter int CW  = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic                  iCLK,
    input  logic                  nRST,
    input  logic                  E,
    input  logic [LW-1:0]         LENM1,
    input  logic                  WE,
    input  logic [CW-1:0]         WCH,
    input  logic [LEN-1:0]        WMASK,
    output logic [CH-1:0]         oCLK,
    output logic                  oB0,
    output logic [LW-1:0]         oPOS,
    output logic                  oPEND,
    output logic [CH*(LW+1)-1:0]  oSKIPS
);

    localparam logic [LW-1:0] LMAX = LW'(LEN - 1);

    logic [LW-1:0]  pos;
    logic [LW-1:0]  lim;
    logic           wrap;
    logic           commit;
    logic           wr_ok;
    logic           pend;
    logic [LEN-1:0] amask  [CH];
    logic [LEN-1:0] shadow [CH];

    always_comb begin
        lim    = (int'(LENM1) > LEN - 1) ? LMAX : LENM1;
        wrap   = (pos >= lim);
        wr_ok  = WE && (int'(WCH) < CH);
        commit = pend && (!E || wrap);
    end

    always_ff @(negedge iCLK or negedge nRST) begin
        if (!nRST) begin
            pos <= '0;
        end else if (E) begin
            pos <= wrap ? '0 : pos + LW'(1);
        end
    end

    // A write in the commit cycle keeps pend set; the copy below still takes pre-write shadows.
    always_ff @(negedge iCLK or negedge nRST) begin
        if (!nRST) begin
            pend <= 1'b0;
        end else if (wr_ok) begin
            pend <= 1'b1;
        end else if (commit) begin
            pend <= 1'b0;
        end
    end

    always_ff @(negedge iCLK or negedge nRST) begin
        if (!nRST) begin
            for (int unsigned c = 0; c < CH; c++) begin
                shadow[c] <= '0;
            end
        end else if (wr_ok) begin
            shadow[WCH] <= WMASK;
        end
    end

    always_ff @(negedge iCLK or negedge nRST) begin
        if (!nRST) begin
            for (int unsigned c = 0; c < CH; c++) begin
                amask[c] <= '0;
            end
        end else if (commit) begin
            for (int unsigned c = 0; c < CH; c++) begin
                amask[c] <= shadow[c];
            end
        end
    end

    // Gate depends only on registers that move while iCLK is low, so no glitch reaches oCLK.
    always_comb begin
        oCLK = '0;
        for (int unsigned c = 0; c < CH; c++) begin
            oCLK[c] = iCLK & ~(E & amask[c][pos]);
        end
    end

    assign oB0   = E & (pos == '0);
    assign oPOS  = pos;
    assign oPEND = pend;

`ifdef SKIPRING_SKIPSTAT_EN
    logic [LW:0] acc  [CH];
    logic [LW:0] last [CH];

    always_ff @(negedge iCLK or negedge nRST) begin
        if (!nRST) begin
            for (int unsigned c = 0; c < CH; c++) begin
                acc[c]  <= '0;
                last[c] <= '0;
            end
        end else if (E) begin
            for (int unsigned c = 0; c < CH; c++) begin
                if (wrap) begin
                    last[c] <= acc[c] + (LW+1)'(amask[c][pos]);
                    acc[c]  <= '0;
                end else begin
                    acc[c]  <= acc[c] + (LW+1)'(amask[c][pos]);
                end
            end
        end
    end

    always_comb begin
        oSKIPS = '0;
        for (int unsigned c = 0; c < CH; c++) begin
            oSKIPS[c*(LW+1) +: (LW+1)] = last[c];
        end
    end
`else
    assign oSKIPS = '0;
`endif

endmodule

// File: tb/tb_skipring_mc.sv
// Self-checking bench for skipring_mc: directed scenarios then random traffic against a rule-level model.
module tb_skipring_mc;

    localparam int LEN = 16;
    localparam int CH  = 4;
    localparam int LW  = 4;
    localparam int CW  = 2;
    localparam int SW  = CH * (LW + 1);

    logic            iCLK  = 1'b1;
    logic            nRST  = 1'b0;
    logic            E     = 1'b0;
    logic [LW-1:0]   LENM1 = 4'd15;
    logic            WE    = 1'b0;
    logic [CW-1:0]   WCH   = '0;
    logic [LEN-1:0]  WMASK = '0;
    logic [CH-1:0]   oCLK;
    logic            oB0;
    logic [LW-1:0]   oPOS;
    logic            oPEND;
    logic [SW-1:0]   oSKIPS;

    int total = 0;
    int bad   = 0;

    // reference state
    int             m_pos;
    bit             m_pend;
    logic [LEN-1:0] m_am [CH];
    logic [LEN-1:0] m_sh [CH];
    int             m_acc [CH];
    int             m_sk  [CH];

    logic [CH-1:0]  seen_clk;
    logic           seen_b0;

    skipring_mc #(.LEN(LEN), .CH(CH)) dut (
        .iCLK(iCLK), .nRST(nRST), .E(E), .LENM1(LENM1), .WE(WE), .WCH(WCH), .WMASK(WMASK),
        .oCLK(oCLK), .oB0(oB0), .oPOS(oPOS), .oPEND(oPEND), .oSKIPS(oSKIPS)
    );

    always #5 iCLK = ~iCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pos  = 0;
        m_pend = 0;
        for (int c = 0; c < CH; c++) begin
            m_am[c]  = '0;
            m_sh[c]  = '0;
            m_acc[c] = 0;
            m_sk[c]  = 0;
        end
    endtask

    function automatic logic [SW-1:0] exp_skips();
        logic [SW-1:0] r;
        r = '0;
`ifdef SKIPRING_SKIPSTAT_EN
        for (int c = 0; c < CH; c++) r[c*(LW+1) +: (LW+1)] = (LW+1)'(m_sk[c]);
`endif
        return r;
    endfunction

    // outputs expected while iCLK is high
    task automatic check_outputs();
        logic [CH-1:0] ec;
        for (int c = 0; c < CH; c++) ec[c] = !(E && m_am[c][m_pos]);
        chk("oclk_hi", 32'(oCLK), 32'(ec));
        chk("ob0", 32'(oB0), 32'(E && (m_pos == 0)));
        chk("opos", 32'(oPOS), 32'(m_pos));
        chk("opend", 32'(oPEND), 32'(m_pend));
        chk("oskips", 32'(oSKIPS), 32'(exp_skips()));
        seen_clk = oCLK;
        seen_b0  = oB0;
    endtask

    // falling-edge update from the behavioural rules
    task automatic model_edge();
        int  lim;
        bit  wrap;
        bit  commit;
        int  hit;
        if (!nRST) return;
        lim  = (int'(LENM1) > LEN - 1) ? LEN - 1 : int'(LENM1);
        wrap = (m_pos >= lim);
        if (E) begin
            for (int c = 0; c < CH; c++) begin
                hit = m_am[c][m_pos] ? 1 : 0;
                if (wrap) begin
                    m_sk[c]  = m_acc[c] + hit;
                    m_acc[c] = 0;
                end else begin
                    m_acc[c] = m_acc[c] + hit;
                end
            end
        end
        commit = m_pend && (!E || wrap);
        if (commit) for (int c = 0; c < CH; c++) m_am[c] = m_sh[c];
        if (WE && int'(WCH) < CH) begin
            m_sh[WCH] = WMASK;
            m_pend    = 1;
        end else if (commit) begin
            m_pend = 0;
        end
        if (E) m_pos = wrap ? 0 : m_pos + 1;
    endtask

    task automatic cyc();
        @(posedge iCLK);
        #1;
        check_outputs();
        @(negedge iCLK);
        model_edge();
        #1;
        chk("oclk_lo", 32'(oCLK), 32'(0));
    endtask

    // run until a frame starts with nothing pending
    task automatic sync_frame();
        int n;
        n = 0;
        while (!(m_pos == 0 && !m_pend) && n < 60) begin
            cyc();
            n++;
        end
        chk("sync_pos", 32'(oPOS), 32'(0));
        chk("sync_pend", 32'(oPEND), 32'(0));
    endtask

    task automatic write1(input int ch, input logic [LEN-1:0] m);
        WE = 1'b1; WCH = CW'(ch); WMASK = m;
        cyc();
        WE = 1'b0;
    endtask

    task automatic count_pulses(input int ch, input int n, output int pulses, output int b0s);
        pulses = 0;
        b0s    = 0;
        for (int i = 0; i < n; i++) begin
            cyc();
            pulses += seen_clk[ch] ? 1 : 0;
            b0s    += seen_b0 ? 1 : 0;
        end
    endtask

    initial begin
        int p, b, n;
        logic [LW-1:0] frozen;
        model_reset();

        // reset with write strobes active
        WE = 1'b1; WMASK = 16'hFFFF;
        for (int i = 0; i < 3; i++) begin
            WCH = CW'(i);
            cyc();
        end
        WE = 1'b0;
        nRST = 1'b1;
        cyc();
        chk("post_reset_pend", 32'(oPEND), 32'(0));

        // full ring, ch0 skips position 0
        E = 1'b1; LENM1 = 4'd15;
        for (int i = 0; i < 5; i++) cyc();
        write1(0, 16'h0001);
        chk("pend_after_write", 32'(oPEND), 32'(1));
        sync_frame();
        count_pulses(0, 16, p, b);
        chk("ch0_pulses16", 32'(p), 32'(15));
        chk("b0_per_frame", 32'(b), 32'(1));
        count_pulses(1, 16, p, b);
        chk("ch1_untouched", 32'(p), 32'(16));

        // 5-position ring, ch1 skips 0 and 2
        LENM1 = 4'd4;
        write1(1, 16'hFFE5);
        sync_frame();
        count_pulses(1, 5, p, b);
        chk("ch1_pulses5", 32'(p), 32'(3));

        // write on the wrap edge itself lands one frame later
        n = 0;
        while (m_pos != 4 && n < 10) begin cyc(); n++; end
        chk("at_wrap", 32'(oPOS), 32'(4));
        write1(2, 16'h0002);
        chk("pend_wrapwrite", 32'(oPEND), 32'(1));
        count_pulses(2, 5, p, b);
        chk("ch2_not_yet", 32'(p), 32'(5));
        count_pulses(2, 5, p, b);
        chk("ch2_applied", 32'(p), 32'(4));

        // disabled ring commits immediately and freezes
        cyc();
        write1(3, 16'hFFFF);
        E = 1'b0;
        frozen = oPOS;
        for (int i = 0; i < 3; i++) cyc();
        chk("frozen_pos", 32'(oPOS), 32'(frozen));
        chk("e0_commit", 32'(oPEND), 32'(0));
        E = 1'b1;
        count_pulses(3, 5, p, b);
        chk("ch3_all_skipped", 32'(p), 32'(0));

        // skip statistics then asynchronous reset mid-frame at pos 7
        LENM1 = 4'd15;
        write1(0, 16'h00FF);
        sync_frame();
        for (int i = 0; i < 16; i++) cyc();
`ifdef SKIPRING_SKIPSTAT_EN
        chk("skips_ch0", 32'(oSKIPS[LW:0]), 32'(8));
`endif
        n = 0;
        while (m_pos != 7 && n < 20) begin cyc(); n++; end
        @(posedge iCLK);
        #1;
        check_outputs();
        chk("gated_pos7", 32'(oCLK[0]), 32'(0));
        #1;
        nRST = 1'b0;
        model_reset();
        #1;
        check_outputs();
        chk("rst_passthru", 32'(oCLK), 32'(4'hF));
        @(negedge iCLK);
        #1;
        for (int i = 0; i < 2; i++) cyc();
        nRST = 1'b1;

        // random traffic
        for (int i = 0; i < 600; i++) begin
            E     = ($urandom_range(0, 7) != 0);
            WE    = ($urandom_range(0, 3) == 0);
            WCH   = CW'($urandom_range(0, CH - 1));
            WMASK = LEN'($urandom);
            if ($urandom_range(0, 31) == 0) LENM1 = LW'($urandom_range(1, 15));
            cyc();
        end
        WE = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
